hand_hit_arbiter: RTL and testbench

- Time-shares one drum_selector instance between the right-hand and left-hand hit detectors.
- Accepts one hit request per hand using a req/ack handshake. Arbitrates round-robin and applies a per-hand retrigger lockout.
- Sequences each accepted hit through the selector with an IDLE/ISSUE/WAIT FSM.
- Buffers the resulting {hand, drum_code} pairs in a small FIFO for the downstream sample-trigger / SPI stage.

---
 rtl/hand_hit_arbiter_if.sv | 38 +++
 rtl/hand_hit_arbiter.sv | 111 +++++++++++
 tb/tb_hand_hit_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hand_hit_arbiter_if.sv
// hand_hit_arbiter_if: hand request ports, selector link and output FIFO port of the arbiter
interface hand_hit_arbiter_if;
    logic               r_req;
    logic [2:0]         r_zone;
    logic signed [31:0] r_pitch;
    logic signed [15:0] r_gyro_z;
    logic               r_ack;
    logic               l_req;
    logic [2:0]         l_zone;
    logic signed [31:0] l_pitch;
    logic signed [15:0] l_gyro_z;
    logic               l_ack;
    logic               sel_valid_in;
    logic [2:0]         sel_zone_id;
    logic [31:0]        sel_pitch;
    logic [15:0]        sel_gyro_z;
    logic               sel_is_left;
    logic               sel_valid_out;
    logic [3:0]         sel_drum_code;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         out_code;
    logic               out_left;
    logic [7:0]         drop_count;
    logic               timeout_err;
    modport slave (
        input  r_req, r_zone, r_pitch, r_gyro_z, l_req, l_zone, l_pitch, l_gyro_z,
        input  sel_valid_out, sel_drum_code, out_ready,
        output r_ack, l_ack, sel_valid_in, sel_zone_id, sel_pitch, sel_gyro_z, sel_is_left,
        output out_valid, out_code, out_left, drop_count, timeout_err
    );
    modport master (
        output r_req, r_zone, r_pitch, r_gyro_z, l_req, l_zone, l_pitch, l_gyro_z,
        output sel_valid_out, sel_drum_code, out_ready,
        input  r_ack, l_ack, sel_valid_in, sel_zone_id, sel_pitch, sel_gyro_z, sel_is_left,
        input  out_valid, out_code, out_left, drop_count, timeout_err
    );
endinterface

// File: rtl/hand_hit_arbiter.sv
// hand_hit_arbiter: round-robin two-hand arbiter with retrigger lockout feeding one drum_selector and a result FIFO
module hand_hit_arbiter #(
    parameter int          DEPTH          = 4,
    parameter logic [15:0] LOCKOUT_CYCLES = 16'd50000,
    parameter int          TIMEOUT_CYCLES = 4
) (
    input logic             clk,
    input logic             rst_n,
    hand_hit_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t        state, state_nx;
    logic [TW-1:0] tcnt, tcnt_nx;
    logic [15:0]   lock_r, lock_l;
    logic          last_left, ack_r_q, ack_l_q;
    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          el_r, el_l, d_r, d_l, can_grant, g_r, g_l, push, pop, err_set;
    logic [8:0]    drop_sum;
    // the previous-cycle ack guard keeps a slow-to-deassert requester from being acked twice
    assign el_r      = bus.r_req && lock_r == 16'd0 && !ack_r_q;
    assign el_l      = bus.l_req && lock_l == 16'd0 && !ack_l_q;
    assign d_r       = bus.r_req && lock_r != 16'd0 && !ack_r_q;
    assign d_l       = bus.l_req && lock_l != 16'd0 && !ack_l_q;
    assign can_grant = state == IDLE && count < FULL;
    assign g_r       = can_grant && el_r && (!el_l || last_left);
    assign g_l       = can_grant && el_l && (!el_r || !last_left);
    assign bus.r_ack = g_r || d_r;
    assign bus.l_ack = g_l || d_l;
    assign bus.sel_valid_in = state == ISSUE;
    assign push      = state == WAIT && bus.sel_valid_out;
    assign pop       = bus.out_valid && bus.out_ready;
    assign bus.out_valid = count != '0;
    assign bus.out_code  = bus.out_valid ? mem[rd_ptr][3:0] : 4'd0;
    assign bus.out_left  = bus.out_valid && mem[rd_ptr][4];
    assign drop_sum  = {1'b0, bus.drop_count} + {8'd0, d_r} + {8'd0, d_l};
    always_comb begin
        state_nx = state;
        tcnt_nx  = tcnt;
        err_set  = 1'b0;
        unique case (state)
            IDLE:  state_nx = (g_r || g_l) ? ISSUE : IDLE;
            ISSUE: begin
                state_nx = WAIT;
                tcnt_nx  = '0;
            end
            WAIT: begin
                if (bus.sel_valid_out) begin
                    state_nx = IDLE;
                end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_nx = IDLE;
                    err_set  = 1'b1;
                end else begin
                    tcnt_nx = tcnt + TW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tcnt  <= '0;
        end else begin
            state <= state_nx;
            tcnt  <= tcnt_nx;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_r          <= 16'd0;
            lock_l          <= 16'd0;
            last_left       <= 1'b1;
            ack_r_q         <= 1'b0;
            ack_l_q         <= 1'b0;
            bus.sel_zone_id <= 3'd0;
            bus.sel_pitch   <= 32'd0;
            bus.sel_gyro_z  <= 16'd0;
            bus.sel_is_left <= 1'b0;
            bus.drop_count  <= 8'd0;
            bus.timeout_err <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
        end else begin
            lock_r    <= g_r ? LOCKOUT_CYCLES : (lock_r != 16'd0 ? lock_r - 16'd1 : lock_r);
            lock_l    <= g_l ? LOCKOUT_CYCLES : (lock_l != 16'd0 ? lock_l - 16'd1 : lock_l);
            last_left <= g_l ? 1'b1 : (g_r ? 1'b0 : last_left);
            ack_r_q   <= bus.r_ack;
            ack_l_q   <= bus.l_ack;
            if (g_r || g_l) begin
                bus.sel_zone_id <= g_l ? bus.l_zone : bus.r_zone;
                bus.sel_pitch   <= g_l ? bus.l_pitch : bus.r_pitch;
                bus.sel_gyro_z  <= g_l ? bus.l_gyro_z : bus.r_gyro_z;
                bus.sel_is_left <= g_l;
            end
            bus.drop_count  <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            bus.timeout_err <= bus.timeout_err || err_set;
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= (push && !pop) ? count + (AW + 1)'(1) : ((pop && !push) ? count - (AW + 1)'(1) : count);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.sel_is_left, bus.sel_drum_code};
    end
endmodule

// File: tb/tb_hand_hit_arbiter.sv
// tb_hand_hit_arbiter: directed scenarios against hand_hit_arbiter with a 1-cycle-latency selector stub
module tb_hand_hit_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic sel_en = 1'b1;
    logic sel_force = 1'b0;
    logic [3:0] code_r = 4'd0;
    logic [3:0] code_l = 4'd0;
    hand_hit_arbiter_if bus();
    hand_hit_arbiter #(.DEPTH(4), .LOCKOUT_CYCLES(16'd10), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;
    // selector stub: answers one cycle after valid_in with a per-hand code chosen by the test
    always @(posedge clk) begin
        bus.sel_valid_out <= (bus.sel_valid_in && sel_en) || sel_force;
        bus.sel_drum_code <= bus.sel_is_left ? code_l : code_r;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic nxt;
        @(posedge clk);
        #1;
    endtask
    task automatic clear_inputs;
        bus.r_req = 0; bus.r_zone = 0; bus.r_pitch = 0; bus.r_gyro_z = 0;
        bus.l_req = 0; bus.l_zone = 0; bus.l_pitch = 0; bus.l_gyro_z = 0;
        bus.out_ready = 0; sel_en = 1; sel_force = 0;
    endtask
    task automatic do_reset;
        rst_n = 0;
        clear_inputs();
        nxt(); nxt();
        rst_n = 1;
        nxt();
    endtask
    task automatic req_hit(input logic left, input logic [2:0] zone, input logic [3:0] code, output bit acked);
        acked = 0;
        if (left) begin code_l = code; bus.l_zone = zone; bus.l_req = 1; end
        else begin code_r = code; bus.r_zone = zone; bus.r_req = 1; end
        for (int i = 0; i < 20 && !acked; i++) begin
            #1;
            if (left ? bus.l_ack : bus.r_ack) acked = 1;
            nxt();
        end
        bus.l_req = 0;
        bus.r_req = 0;
    endtask
    task automatic test_reset;
        rst_n = 0;
        clear_inputs();
        nxt(); nxt();
        #1;
        checks++; if (bus.r_ack !== 1'b0 || bus.l_ack !== 1'b0) begin errors++; $display("FAIL rst_acks: got %b%b want 00", bus.r_ack, bus.l_ack); end
        checks++; if (bus.sel_valid_in !== 1'b0 || bus.sel_is_left !== 1'b0) begin errors++; $display("FAIL rst_sel_ctl: got %b%b want 00", bus.sel_valid_in, bus.sel_is_left); end
        checks++; if (bus.sel_zone_id !== 3'd0 || bus.sel_pitch !== 32'd0 || bus.sel_gyro_z !== 16'd0) begin errors++; $display("FAIL rst_sel_data: got %0d %0d %0d want 0", bus.sel_zone_id, bus.sel_pitch, bus.sel_gyro_z); end
        checks++; if (bus.out_valid !== 1'b0 || bus.out_code !== 4'd0 || bus.out_left !== 1'b0) begin errors++; $display("FAIL rst_out: got %b %0d %b want 0", bus.out_valid, bus.out_code, bus.out_left); end
        checks++; if (bus.drop_count !== 8'd0 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rst_status: got %0d %b want 0", bus.drop_count, bus.timeout_err); end
        rst_n = 1;
        nxt();
    endtask
    task automatic test_single_right;
        do_reset();
        code_r = 4'd5;
        bus.r_req = 1; bus.r_zone = 3'd1; bus.r_pitch = 32'sd1966080; bus.r_gyro_z = 16'sd0;
        #1;
        checks++; if (bus.r_ack !== 1'b1 || bus.l_ack !== 1'b0) begin errors++; $display("FAIL t1_ack_G: got r%b l%b want r1 l0", bus.r_ack, bus.l_ack); end
        nxt();
        bus.r_req = 0;
        #1;
        checks++; if (bus.sel_valid_in !== 1'b1 || bus.sel_is_left !== 1'b0) begin errors++; $display("FAIL t1_issue: got v%b left%b want v1 left0", bus.sel_valid_in, bus.sel_is_left); end
        checks++; if (bus.sel_zone_id !== 3'd1 || bus.sel_pitch !== 32'd1966080) begin errors++; $display("FAIL t1_sel_data: got %0d %0d want 1 1966080", bus.sel_zone_id, bus.sel_pitch); end
        checks++; if (bus.r_ack !== 1'b0) begin errors++; $display("FAIL t1_ack_once: got %b want 0", bus.r_ack); end
        nxt(); #1;
        checks++; if (bus.sel_valid_in !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL t1_G2: got v%b ov%b want 00", bus.sel_valid_in, bus.out_valid); end
        nxt(); #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_code !== 4'd5 || bus.out_left !== 1'b0) begin errors++; $display("FAIL t1_out_G3: got %b %0d %b want 1 5 0", bus.out_valid, bus.out_code, bus.out_left); end
        bus.out_ready = 1;
        nxt();
        bus.out_ready = 0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_code !== 4'd0) begin errors++; $display("FAIL t1_pop: got %b %0d want 0 0", bus.out_valid, bus.out_code); end
    endtask
    task automatic test_tie;
        do_reset();
        code_r = 4'd0; code_l = 4'd1;
        bus.r_req = 1; bus.r_zone = 0; bus.r_pitch = 32'sd0;
        bus.l_req = 1; bus.l_zone = 0; bus.l_pitch = 32'sd1310720; bus.l_gyro_z = 16'sd0;
        #1;
        checks++; if (bus.r_ack !== 1'b1 || bus.l_ack !== 1'b0) begin errors++; $display("FAIL t2_first_right: got r%b l%b want r1 l0", bus.r_ack, bus.l_ack); end
        nxt();
        bus.r_req = 0;
        #1;
        checks++; if (bus.l_ack !== 1'b0 || bus.sel_is_left !== 1'b0) begin errors++; $display("FAIL t2_issue_right: got lack%b left%b want 0 0", bus.l_ack, bus.sel_is_left); end
        nxt(); nxt(); #1;
        checks++; if (bus.l_ack !== 1'b1) begin errors++; $display("FAIL t2_left_G3: got %b want 1", bus.l_ack); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_code !== 4'd0 || bus.out_left !== 1'b0) begin errors++; $display("FAIL t2_head_right: got %b %0d %b want 1 0 0", bus.out_valid, bus.out_code, bus.out_left); end
        nxt();
        bus.l_req = 0;
        #1;
        checks++; if (bus.sel_valid_in !== 1'b1 || bus.sel_is_left !== 1'b1 || bus.sel_pitch !== 32'd1310720) begin errors++; $display("FAIL t2_issue_left: got %b %b %0d want 1 1 1310720", bus.sel_valid_in, bus.sel_is_left, bus.sel_pitch); end
        nxt(); nxt();
        bus.out_ready = 1;
        #1;
        checks++; if (bus.out_code !== 4'd0 || bus.out_left !== 1'b0) begin errors++; $display("FAIL t2_order0: got %0d %b want 0 0", bus.out_code, bus.out_left); end
        nxt(); #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_code !== 4'd1 || bus.out_left !== 1'b1) begin errors++; $display("FAIL t2_order1: got %b %0d %b want 1 1 1", bus.out_valid, bus.out_code, bus.out_left); end
        nxt();
        bus.out_ready = 0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t2_empty: got %b want 0", bus.out_valid); end
    endtask
    task automatic test_lockout;
        do_reset();
        code_r = 4'd7;
        bus.r_req = 1; bus.r_zone = 3'd2;
        #1;
        checks++; if (bus.r_ack !== 1'b1) begin errors++; $display("FAIL t3_grant: got %b want 1", bus.r_ack); end
        nxt();
        bus.r_req = 0;
        repeat (4) nxt();
        bus.r_req = 1;
        #1;
        checks++; if (bus.r_ack !== 1'b1 || bus.sel_valid_in !== 1'b0) begin errors++; $display("FAIL t3_drop_ack: got ack%b v%b want 1 0", bus.r_ack, bus.sel_valid_in); end
        nxt();
        bus.r_req = 0;
        #1;
        checks++; if (bus.drop_count !== 8'd1 || bus.sel_valid_in !== 1'b0) begin errors++; $display("FAIL t3_drop_count: got %0d v%b want 1 0", bus.drop_count, bus.sel_valid_in); end
        repeat (4) nxt();
        bus.r_req = 1;
        #1;
        checks++; if (bus.r_ack !== 1'b1) begin errors++; $display("FAIL t3_drop_edge: got %b want 1", bus.r_ack); end
        nxt();
        bus.r_req = 0;
        #1;
        checks++; if (bus.drop_count !== 8'd2 || bus.sel_valid_in !== 1'b0) begin errors++; $display("FAIL t3_drop_edge_cnt: got %0d v%b want 2 0", bus.drop_count, bus.sel_valid_in); end
        nxt();
        bus.r_req = 1;
        #1;
        checks++; if (bus.r_ack !== 1'b1) begin errors++; $display("FAIL t3_regrant: got %b want 1", bus.r_ack); end
        nxt();
        bus.r_req = 0;
        #1;
        checks++; if (bus.sel_valid_in !== 1'b1 || bus.drop_count !== 8'd2) begin errors++; $display("FAIL t3_regrant_issue: got v%b cnt%0d want 1 2", bus.sel_valid_in, bus.drop_count); end
    endtask
    task automatic test_fifo_full;
        bit a;
        bit seen;
        logic [3:0] exp_codes [4];
        exp_codes = '{4'd2, 4'd3, 4'd4, 4'd9};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_hit(i[0], 3'(i), 4'(i + 1), a);
            checks++; if (a !== 1'b1) begin errors++; $display("FAIL t4_fill_ack%0d: got %b want 1", i, a); end
            repeat (12) nxt();
        end
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_code !== 4'd1) begin errors++; $display("FAIL t4_full_head: got %b %0d want 1 1", bus.out_valid, bus.out_code); end
        code_r = 4'd9; bus.r_zone = 0; bus.r_req = 1;
        seen = 0;
        repeat (12) begin
            #1;
            if (bus.r_ack) seen = 1;
            nxt();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL t4_held: got ack %b want 0", seen); end
        bus.out_ready = 1;
        #1;
        checks++; if (bus.r_ack !== 1'b0) begin errors++; $display("FAIL t4_pop_cycle: got %b want 0", bus.r_ack); end
        nxt();
        bus.out_ready = 0;
        #1;
        checks++; if (bus.r_ack !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_code !== 4'd2 || bus.out_left !== 1'b1) begin errors++; $display("FAIL t4_after_pop: got ack%b %b %0d %b want 1 1 2 1", bus.r_ack, bus.out_valid, bus.out_code, bus.out_left); end
        nxt();
        bus.r_req = 0;
        nxt(); nxt();
        bus.out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_code !== exp_codes[i]) begin errors++; $display("FAIL t4_drain%0d: got %b %0d want 1 %0d", i, bus.out_valid, bus.out_code, exp_codes[i]); end
            nxt();
        end
        bus.out_ready = 0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t4_empty: got %b want 0", bus.out_valid); end
    endtask
    task automatic test_timeout;
        do_reset();
        sel_en = 0;
        bus.r_req = 1;
        #1;
        checks++; if (bus.r_ack !== 1'b1) begin errors++; $display("FAIL t5_grant: got %b want 1", bus.r_ack); end
        nxt();
        bus.r_req = 0;
        repeat (4) nxt();
        #1;
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL t5_early: got %b want 0", bus.timeout_err); end
        nxt();
        code_l = 4'd3; sel_en = 1; bus.l_req = 1;
        #1;
        checks++; if (bus.timeout_err !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL t5_err: got err%b ov%b want 1 0", bus.timeout_err, bus.out_valid); end
        checks++; if (bus.l_ack !== 1'b1) begin errors++; $display("FAIL t5_idle_grant: got %b want 1", bus.l_ack); end
        nxt();
        bus.l_req = 0;
        #1;
        checks++; if (bus.sel_valid_in !== 1'b1 || bus.sel_is_left !== 1'b1) begin errors++; $display("FAIL t5_issue: got %b %b want 1 1", bus.sel_valid_in, bus.sel_is_left); end
        nxt(); nxt(); #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_code !== 4'd3 || bus.out_left !== 1'b1 || bus.timeout_err !== 1'b1) begin errors++; $display("FAIL t5_recover: got %b %0d %b err%b want 1 3 1 1", bus.out_valid, bus.out_code, bus.out_left, bus.timeout_err); end
    endtask
    task automatic test_reset_mid;
        bit a;
        do_reset();
        req_hit(1'b0, 3'd0, 4'd2, a);
        req_hit(1'b1, 3'd0, 4'd6, a);
        bus.r_req = 1;
        #1;
        checks++; if (bus.r_ack !== 1'b1) begin errors++; $display("FAIL t6_drop: got %b want 1", bus.r_ack); end
        nxt();
        bus.r_req = 0;
        repeat (12) nxt();
        sel_en = 0;
        req_hit(1'b0, 3'd3, 4'd7, a);
        nxt(); nxt();
        #1;
        checks++; if (bus.drop_count !== 8'd1 || bus.out_valid !== 1'b1 || bus.out_code !== 4'd2 || bus.sel_zone_id !== 3'd3) begin errors++; $display("FAIL t6_before: got cnt%0d %b %0d z%0d want 1 1 2 3", bus.drop_count, bus.out_valid, bus.out_code, bus.sel_zone_id); end
        rst_n = 0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_code !== 4'd0 || bus.drop_count !== 8'd0 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL t6_async: got %b %0d cnt%0d err%b want 0", bus.out_valid, bus.out_code, bus.drop_count, bus.timeout_err); end
        checks++; if (bus.sel_valid_in !== 1'b0 || bus.sel_zone_id !== 3'd0 || bus.r_ack !== 1'b0) begin errors++; $display("FAIL t6_async_sel: got v%b z%0d ack%b want 0", bus.sel_valid_in, bus.sel_zone_id, bus.r_ack); end
        nxt(); nxt();
        rst_n = 1;
        sel_en = 1;
        sel_force = 1;
        nxt();
        sel_force = 0;
        nxt(); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t6_late_resp: got %b want 0", bus.out_valid); end
        nxt();
        code_r = 4'd8; bus.r_req = 1;
        #1;
        checks++; if (bus.r_ack !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL t6_regrant: got ack%b ov%b want 1 0", bus.r_ack, bus.out_valid); end
        nxt();
        bus.r_req = 0;
        nxt(); nxt(); #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_code !== 4'd8) begin errors++; $display("FAIL t6_after: got %b %0d want 1 8", bus.out_valid, bus.out_code); end
    endtask
    initial begin
        clear_inputs();
        test_reset();
        test_single_right();
        test_tie();
        test_lockout();
        test_fifo_full();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
